// File: rtl/counter_down_nbit.sv
// counter_down_nbit: loadable N-bit down counter with a registered terminal-count pulse.
// Define COUNTER_DOWN_RELOAD_EN to add the auto_reload port for periodic operation.
module counter_down_nbit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
`ifdef COUNTER_DOWN_RELOAD_EN
    input  logic         auto_reload,
`endif
    output logic [N-1:0] count,
    output logic         tc,
    output logic         busy
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [N-1:0] ONE = N'(1);
    state_t state, state_next;
    logic [N-1:0] count_next, reload_val;
    logic tc_next, expire, reload_act, step;
`ifdef COUNTER_DOWN_RELOAD_EN
    logic [N-1:0] reload_reg;
    assign reload_act = auto_reload;
    assign reload_val = reload_reg;
    always_ff @(posedge clk)
        if (rst) reload_reg <= '0;
        else if (load) reload_reg <= load_val;
`else
    assign reload_act = 1'b0;
    assign reload_val = '0;
`endif
    assign step = state == RUN && en;
    assign expire = step && count == ONE;
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_next;
    always_comb begin
        state_next = load ? (load_val != '0 ? RUN : IDLE)
                   : (expire && !reload_act) ? IDLE : state;
    end
    always_comb begin
        busy = state == RUN;
    end
    // Decrement only above 1; the 1 -> 0/reload step is the expiry, so 0 never wraps.
    always_comb begin
        count_next = load ? load_val
                   : !step ? count
                   : count > ONE ? count - ONE
                   : expire ? (reload_act ? reload_val : '0)
                   : count;
        tc_next = load ? load_val == '0 : expire;
    end
    always_ff @(posedge clk)
        if (rst) begin
            count <= '0;
            tc <= 1'b0;
        end else begin
            count <= count_next;
            tc <= tc_next;
        end
endmodule

// File: tb/tb_counter_down_nbit.sv
// tb_counter_down_nbit: directed checks of the 4-bit down counter.
module tb_counter_down_nbit;
    logic clk = 1'b0;
    logic rst, en, load;
    logic [3:0] load_val, count;
    logic tc, busy;
`ifdef COUNTER_DOWN_RELOAD_EN
    logic auto_reload = 1'b0;
`endif
    int total = 0;
    int fails = 0;

    counter_down_nbit #(.N(4)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .load(load),
        .load_val(load_val),
`ifdef COUNTER_DOWN_RELOAD_EN
        .auto_reload(auto_reload),
`endif
        .count(count),
        .tc(tc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] c, input logic t, input logic b);
        total++;
        assert (count === c && tc === t && busy === b)
        else begin
            fails++;
            $error("FAIL %s: got count=%0d tc=%b busy=%b, expected count=%0d tc=%b busy=%b",
                   tag, count, tc, busy, c, t, b);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd7;
        step(); chk("reset_over_load", 4'd0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b0;
        step(); chk("reset_hold", 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        // count 3,2,1,0 with tc on the 0
        load = 1'b1; load_val = 4'd3; en = 1'b1;
        step(); chk("load3", 4'd3, 1'b0, 1'b1);
        load = 1'b0;
        step(); chk("dec2", 4'd2, 1'b0, 1'b1);
        step(); chk("dec1", 4'd1, 1'b0, 1'b1);
        step(); chk("expire", 4'd0, 1'b1, 1'b0);
        step(); chk("idle_after", 4'd0, 1'b0, 1'b0);
        // pause
        load = 1'b1; load_val = 4'd5;
        step(); chk("load5", 4'd5, 1'b0, 1'b1);
        load = 1'b0;
        step(); chk("dec4", 4'd4, 1'b0, 1'b1);
        en = 1'b0;
        step(); chk("pause1", 4'd4, 1'b0, 1'b1);
        step(); chk("pause2", 4'd4, 1'b0, 1'b1);
        en = 1'b1;
        step(); chk("resume3", 4'd3, 1'b0, 1'b1);
        step(); chk("resume2", 4'd2, 1'b0, 1'b1);
        step(); chk("resume1", 4'd1, 1'b0, 1'b1);
        step(); chk("resume_exp", 4'd0, 1'b1, 1'b0);
        // load wins on the expiry edge
        load = 1'b1; load_val = 4'd2;
        step(); chk("load2", 4'd2, 1'b0, 1'b1);
        load = 1'b0;
        step(); chk("at1", 4'd1, 1'b0, 1'b1);
        load = 1'b1; load_val = 4'd9;
        step(); chk("load_on_exp", 4'd9, 1'b0, 1'b1);
        // load while paused
        en = 1'b0; load_val = 4'd6;
        step(); chk("load_paused", 4'd6, 1'b0, 1'b1);
        // reset mid-count
        en = 1'b1; load_val = 4'd15;
        step(); chk("load15", 4'd15, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 14; i >= 10; i--) begin
            step(); chk("run_to_10", 4'(i), 1'b0, 1'b1);
        end
        rst = 1'b1;
        step(); chk("rst_mid", 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); chk("no_restart1", 4'd0, 1'b0, 1'b0);
        step(); chk("no_restart2", 4'd0, 1'b0, 1'b0);
        // immediate expiry on load of 0
        load = 1'b1; load_val = 4'd0;
        step(); chk("load0", 4'd0, 1'b1, 1'b0);
        load = 1'b0;
        step(); chk("load0_after", 4'd0, 1'b0, 1'b0);
        step(); chk("no_wrap", 4'd0, 1'b0, 1'b0);
        // full-range period
        load = 1'b1; load_val = 4'd15;
        step(); chk("max_load", 4'd15, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 14; i >= 1; i--) begin
            step(); chk("max_run", 4'(i), 1'b0, 1'b1);
        end
        step(); chk("max_expire", 4'd0, 1'b1, 1'b0);
        step(); chk("max_idle", 4'd0, 1'b0, 1'b0);
`ifdef COUNTER_DOWN_RELOAD_EN
        auto_reload = 1'b1; load = 1'b1; load_val = 4'd3;
        step(); chk("rl_load3", 4'd3, 1'b0, 1'b1);
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); chk("rl_2", 4'd2, 1'b0, 1'b1);
            step(); chk("rl_1", 4'd1, 1'b0, 1'b1);
            step(); chk("rl_wrap", 4'd3, 1'b1, 1'b1);
        end
        auto_reload = 1'b0;
        step(); chk("rl_off_2", 4'd2, 1'b0, 1'b1);
        step(); chk("rl_off_1", 4'd1, 1'b0, 1'b1);
        step(); chk("rl_off_exp", 4'd0, 1'b1, 1'b0);
`endif
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/counter_down_nbit.md
COUNTER_DOWN_NBIT -- requirements
Module: counter_down_nbit

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the counter width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port en, input, 1 bit: count enable; decrement permitted while high.
REQ-005 The block SHALL have port load, input, 1 bit: load strobe; captures load_val.
REQ-006 The block SHALL have port load_val, input, N bits: start and reload value, unsigned.
REQ-007 The block SHALL have port auto_reload, input, 1 bit: periodic mode select; present only when COUNTER_DOWN_RELOAD_EN is defined.
REQ-008 The block SHALL have port count, output, N bits: current counter value, registered.
REQ-009 The block SHALL have port tc, output, 1 bit: terminal-count pulse, registered, one cycle wide.
REQ-010 The block SHALL have port busy, output, 1 bit: high exactly while the state is RUN.

Function
REQ-011 The block SHALL implement two states: IDLE (not counting) and RUN (counting down).
REQ-012 load=1 SHALL take priority over en in any state: count<=load_val, reload_reg<=load_val, tc<=0.
REQ-013 Load with load_val!=0 SHALL enter RUN with count visible on the edge after load.
REQ-014 Load with load_val==0 SHALL go to IDLE with count<=0 and tc<=1 for one cycle (immediate expiry).
REQ-015 In RUN with en=1, load=0 and count>1, the block SHALL set count<=count-1 and tc<=0.
REQ-016 In RUN with en=1, load=0 and count==1, the block SHALL set tc<=1 for exactly one cycle.
REQ-017 On that expiry edge without reload active, the block SHALL set count<=0 and state<=IDLE.
REQ-018 On that expiry edge with reload active, the block SHALL set count<=reload_reg and stay in RUN; period = load_val enabled cycles.
REQ-019 In RUN with en=0, the block SHALL hold count and set tc<=0 (pause, no loss of state).
REQ-020 In IDLE, count SHALL hold, en SHALL be ignored, and tc SHALL be 0 except per REQ-014/REQ-017.
REQ-021 count SHALL never wrap from 0 to 2^N-1; decrement is never applied at 0.
REQ-022 Load coinciding with an expiry edge SHALL win: no tc, count<=load_val.
REQ-023 Arithmetic SHALL be N-bit unsigned; load_val = 2^N-1 SHALL be legal and give a 2^N-1 cycle period.

Reset
REQ-024 rst=1 at a rising edge SHALL force count=0, tc=0, busy=0, reload_reg=0 and state=IDLE, overriding load and en.
REQ-025 Reset asserted mid-count SHALL abort the count with no tc pulse; the block restarts only on a new load.

Configuration
REQ-026 With COUNTER_DOWN_RELOAD_EN defined, the auto_reload port SHALL exist and auto_reload=1 SHALL select REQ-018.
REQ-027 Without COUNTER_DOWN_RELOAD_EN, the auto_reload port and reload path SHALL be absent, and expiry SHALL always follow REQ-017.

Verification
REQ-028 N=4: rst, then load_val=3 with en=1 held -> count 3,2,1,0 on successive edges, tc=1 only with count=0, then busy=0.
REQ-029 Load 5, en low for 2 cycles after count=4 -> count holds 4 for 2 cycles, tc=0, busy=1, then resumes 3,2,1,0.
REQ-030 Reload build: load 3 with auto_reload=1 and en=1 -> count 3,2,1,3,2,1,...; tc pulses every 3rd cycle; busy stays 1.
REQ-031 Load 2, then load 9 on the expiry edge -> no tc, count=9, busy=1.
REQ-032 Load 15 with en=1, rst=1 when count=10 -> next edge count=0, busy=0, tc=0; en alone never restarts it.
REQ-033 Load_val=0 -> count=0, tc=1 for one cycle, busy=0; en=1 in IDLE -> count stays 0, no wrap to 15.
